ahb_reg_slave: RTL and testbench

AHB-Lite slave front end that decodes a parameterised address window, pipelines the address phase into the data phase, and drives a simple request/acknowledge register-bank port. It generates HREADYOUT wait states and two-cycle ERROR responses. Malformed or out-of-range transfers and backend timeouts are reported on the bus instead of being silently dropped. It sits between the AHB interconnect and the sensor register bank.

---
 rtl/ahb_reg_slave.sv | 178 +++++++++++++++++
 tb/tb_ahb_reg_slave.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : ahb_reg_slave
// Purpose  : AHB-Lite slave front end for the sensor register bank. Decodes
//            an address window, carries the address phase into the data
//            phase, and drives a request/acknowledge register-bank port.
//            Produces HREADYOUT wait states, two-cycle ERROR responses for
//            malformed or out-of-window transfers, and a timeout ERROR when
//            the backend does not acknowledge within WAIT_MAX cycles.
// Ports    : clk, rst (async, active-high)
//            HSELx/HADDR/HTRANS/HWRITE/HSIZE/HBURST/HREADY : address phase
//            HWDATA                         : write data (data phase)
//            HREADYOUT/HRESP/HRDATA         : slave response
//            reg_req/reg_write/reg_idx/reg_wdata : backend request
//            reg_rdata/reg_ack              : backend completion
//            ok_cnt/err_cnt                 : only with AHB_REG_SLAVE_STATS_EN
// Config   : define AHB_REG_SLAVE_STATS_EN to add saturating OKAY/ERROR
//            transfer counters.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_reg_slave #(
   parameter logic [31:0] ADDR_BASE = 32'hF0F0_0000,
   parameter logic [31:0] ADDR_MASK = 32'hFFFF_F000,
   parameter int          NUM_REGS  = 16,
   parameter int          WAIT_MAX  = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        HSELx,
   input  logic [31:0]                 HADDR,
   input  logic [1:0]                  HTRANS,
   input  logic                        HWRITE,
   input  logic [2:0]                  HSIZE,
   input  logic [2:0]                  HBURST,
   input  logic                        HREADY,
   input  logic [31:0]                 HWDATA,
   output logic                        HREADYOUT,
   output logic                        HRESP,
   output logic [31:0]                 HRDATA,
   output logic                        reg_req,
   output logic                        reg_write,
   output logic [$clog2(NUM_REGS)-1:0] reg_idx,
   output logic [31:0]                 reg_wdata,
   input  logic [31:0]                 reg_rdata,
   input  logic                        reg_ack
`ifdef AHB_REG_SLAVE_STATS_EN
   ,
   output logic [15:0]                 ok_cnt,
   output logic [15:0]                 err_cnt
`endif
);

   localparam int                  c_idx_w     = $clog2(NUM_REGS);
   localparam int                  c_cnt_w     = $clog2(WAIT_MAX + 1);
   localparam logic [9:0]          c_num_regs  = 10'(NUM_REGS);
   localparam logic [c_cnt_w-1:0]  c_wait_last = c_cnt_w'(WAIT_MAX - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_ERR1   = 2'd2,
      ST_ERR2   = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_write;
   logic [c_idx_w-1:0]   r_idx;
   logic [c_cnt_w-1:0]   r_wait_cnt;

   logic                 w_accept;
   logic                 w_bad;
   logic                 w_can_take;
   logic                 w_take;

   // Burst type and the NONSEQ/SEQ distinction do not change how a beat is
   // handled: every beat is an independent single access.
   logic                 w_unused;
   assign w_unused = &{1'b0, HBURST, HTRANS[0]};

   // NONSEQ and SEQ both have HTRANS[1] set; IDLE and BUSY do not.
   assign w_accept = HSELx & HREADY & HTRANS[1];

   assign w_bad = ((HADDR & ADDR_MASK) != ADDR_BASE) |
                  (HADDR[11:2] >= c_num_regs)        |
                  (HSIZE != 3'b010)                   |
                  (HADDR[1:0] != 2'b00);

   // An address phase is only taken in a cycle where this slave is
   // completing (or has no) data phase.
   assign w_take = w_can_take & w_accept;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_write    <= 1'b0;
         r_idx      <= '0;
         r_wait_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_take) begin
            r_write    <= HWRITE;
            r_idx      <= HADDR[2 +: c_idx_w];
            r_wait_cnt <= '0;
         end else if ((r_state == ST_ACCESS) && !reg_ack) begin
            r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_can_take  = 1'b0;
      HREADYOUT   = 1'b1;
      HRESP       = 1'b0;
      HRDATA      = 32'h0;
      reg_req     = 1'b0;
      reg_write   = 1'b0;
      reg_idx     = '0;
      reg_wdata   = 32'h0;
      case (r_state)
         ST_IDLE: begin
            w_can_take = 1'b1;
            if (w_accept) w_state_nxt = w_bad ? ST_ERR1 : ST_ACCESS;
         end
         ST_ACCESS: begin
            reg_req   = 1'b1;
            reg_write = r_write;
            reg_idx   = r_idx;
            reg_wdata = HWDATA;
            HREADYOUT = reg_ack;
            if (reg_ack) begin
               w_can_take = 1'b1;
               if (!r_write) HRDATA = reg_rdata;
               if (w_accept) w_state_nxt = w_bad ? ST_ERR1 : ST_ACCESS;
               else          w_state_nxt = ST_IDLE;
            end else if (r_wait_cnt == c_wait_last) begin
               // This is the WAIT_MAX-th unacknowledged cycle: give up.
               w_state_nxt = ST_ERR1;
            end
         end
         ST_ERR1: begin
            HREADYOUT   = 1'b0;
            HRESP       = 1'b1;
            w_state_nxt = ST_ERR2;
         end
         ST_ERR2: begin
            HRESP      = 1'b1;
            w_can_take = 1'b1;
            if (w_accept) w_state_nxt = w_bad ? ST_ERR1 : ST_ACCESS;
            else          w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

`ifdef AHB_REG_SLAVE_STATS_EN
   logic [15:0] r_ok_cnt;
   logic [15:0] r_err_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ok_cnt  <= 16'h0;
         r_err_cnt <= 16'h0;
      end else begin
         if ((r_state == ST_ACCESS) && reg_ack && (r_ok_cnt != 16'hFFFF))
            r_ok_cnt <= r_ok_cnt + 16'h1;
         if ((r_state == ST_ERR2) && (r_err_cnt != 16'hFFFF))
            r_err_cnt <= r_err_cnt + 16'h1;
      end
   end

   assign ok_cnt  = r_ok_cnt;
   assign err_cnt = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ahb_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_reg_slave
// Purpose  : Directed self-checking bench for ahb_reg_slave. Single-slave
//            system: bus HREADY is the slave's own HREADYOUT. Inputs change
//            1 time unit after the rising edge; outputs are checked on the
//            falling edge. Counter checks are active when
//            AHB_REG_SLAVE_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_reg_slave;

   localparam logic [1:0] c_idle   = 2'b00;
   localparam logic [1:0] c_busy   = 2'b01;
   localparam logic [1:0] c_nonseq = 2'b10;
   localparam logic [1:0] c_seq    = 2'b11;

   logic        clk;
   logic        rst;
   logic        HSELx;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic        HREADY;
   logic [31:0] HWDATA;
   logic        HREADYOUT;
   logic        HRESP;
   logic [31:0] HRDATA;
   logic        reg_req;
   logic        reg_write;
   logic [3:0]  reg_idx;
   logic [31:0] reg_wdata;
   logic [31:0] reg_rdata;
   logic        reg_ack;
`ifdef AHB_REG_SLAVE_STATS_EN
   logic [15:0] ok_cnt;
   logic [15:0] err_cnt;
`endif

   int n_checks = 0;
   int n_fails  = 0;
   int exp_ok   = 0;
   int exp_err  = 0;

   assign HREADY = HREADYOUT;

   ahb_reg_slave u_dut (
      .clk       (clk),
      .rst       (rst),
      .HSELx     (HSELx),
      .HADDR     (HADDR),
      .HTRANS    (HTRANS),
      .HWRITE    (HWRITE),
      .HSIZE     (HSIZE),
      .HBURST    (HBURST),
      .HREADY    (HREADY),
      .HWDATA    (HWDATA),
      .HREADYOUT (HREADYOUT),
      .HRESP     (HRESP),
      .HRDATA    (HRDATA),
      .reg_req   (reg_req),
      .reg_write (reg_write),
      .reg_idx   (reg_idx),
      .reg_wdata (reg_wdata),
      .reg_rdata (reg_rdata),
      .reg_ack   (reg_ack)
`ifdef AHB_REG_SLAVE_STATS_EN
      ,
      .ok_cnt    (ok_cnt),
      .err_cnt   (err_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic addr_ph(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                          input logic [1:0] tr);
      HSELx  = 1'b1;
      HADDR  = a;
      HWRITE = wr;
      HSIZE  = sz;
      HTRANS = tr;
   endtask

   task automatic bus_idle();
      HSELx  = 1'b0;
      HADDR  = 32'h0;
      HWRITE = 1'b0;
      HSIZE  = 3'b010;
      HTRANS = c_idle;
      HBURST = 3'b000;
   endtask

   task automatic chk_stats(input string tag);
`ifdef AHB_REG_SLAVE_STATS_EN
      chk({tag, "_ok_cnt"},  {16'h0, ok_cnt},  32'(exp_ok));
      chk({tag, "_err_cnt"}, {16'h0, err_cnt}, 32'(exp_err));
`else
      chk({tag, "_hresp_idle"}, {31'h0, HRESP}, 32'h0);
`endif
   endtask

   logic [31:0] bad_addr [4];
   logic [2:0]  bad_size [4];
   logic [1:0]  rb_trans [6];
   int          rb_aidx  [6];
   int          rb_didx  [6];

   initial begin
      rst       = 1'b1;
      HWDATA    = 32'h0;
      reg_rdata = 32'h0;
      reg_ack   = 1'b0;
      bus_idle();

      // ---------------- reset state ----------------
      mid();
      chk("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
      chk("rst_hresp",     {31'h0, HRESP},     32'h0);
      chk("rst_hrdata",    HRDATA,             32'h0);
      chk("rst_reg_req",   {31'h0, reg_req},   32'h0);
      chk("rst_reg_write", {31'h0, reg_write}, 32'h0);
      chk("rst_reg_idx",   {28'h0, reg_idx},   32'h0);
      chk("rst_reg_wdata", reg_wdata,          32'h0);
      chk_stats("rst");
      next_cyc();
      rst = 1'b0;

      // ---------------- zero-wait write ----------------
      next_cyc();
      addr_ph(32'hF0F0_0008, 1'b1, 3'b010, c_nonseq);
      mid();
      chk("wr_addr_ready", {31'h0, HREADYOUT}, 32'h1);
      next_cyc();
      bus_idle();
      HWDATA  = 32'hDEAD_BEEF;
      reg_ack = 1'b1;
      mid();
      chk("wr_reg_req",   {31'h0, reg_req},   32'h1);
      chk("wr_reg_write", {31'h0, reg_write}, 32'h1);
      chk("wr_reg_idx",   {28'h0, reg_idx},   32'h2);
      chk("wr_reg_wdata", reg_wdata,          32'hDEAD_BEEF);
      chk("wr_hreadyout", {31'h0, HREADYOUT}, 32'h1);
      chk("wr_hresp",     {31'h0, HRESP},     32'h0);
      exp_ok++;
      next_cyc();
      reg_ack = 1'b0;
      HWDATA  = 32'h0;
      mid();
      chk("wr_done_req", {31'h0, reg_req}, 32'h0);

      // ---------------- read with 3 wait states ----------------
      next_cyc();
      addr_ph(32'hF0F0_0014, 1'b0, 3'b010, c_nonseq);
      mid();
      for (int i = 0; i < 3; i++) begin
         next_cyc();
         bus_idle();
         mid();
         chk($sformatf("rd_wait%0d_hreadyout", i), {31'h0, HREADYOUT}, 32'h0);
         chk($sformatf("rd_wait%0d_hrdata", i), HRDATA, 32'h0);
      end
      chk("rd_reg_idx",   {28'h0, reg_idx},   32'h5);
      chk("rd_reg_write", {31'h0, reg_write}, 32'h0);
      next_cyc();
      reg_ack   = 1'b1;
      reg_rdata = 32'h1234_5678;
      mid();
      chk("rd_hreadyout", {31'h0, HREADYOUT}, 32'h1);
      chk("rd_hrdata",    HRDATA,             32'h1234_5678);
      chk("rd_hresp",     {31'h0, HRESP},     32'h0);
      exp_ok++;
      next_cyc();
      reg_ack   = 1'b0;
      reg_rdata = 32'h0;
      mid();
      chk("rd_after_hrdata", HRDATA, 32'h0);

      // ---------------- malformed / out-of-window transfers ----------------
      bad_addr[0] = 32'hF0F0_0040; bad_size[0] = 3'b010;
      bad_addr[1] = 32'hF0F0_0008; bad_size[1] = 3'b001;
      bad_addr[2] = 32'hF0F0_0002; bad_size[2] = 3'b010;
      bad_addr[3] = 32'hF0F1_0000; bad_size[3] = 3'b010;
      for (int k = 0; k < 4; k++) begin
         next_cyc();
         addr_ph(bad_addr[k], 1'b1, bad_size[k], c_nonseq);
         mid();
         next_cyc();
         bus_idle();
         mid();
         chk($sformatf("bad%0d_e1_hreadyout", k), {31'h0, HREADYOUT}, 32'h0);
         chk($sformatf("bad%0d_e1_hresp", k),     {31'h0, HRESP},     32'h1);
         chk($sformatf("bad%0d_e1_req", k),       {31'h0, reg_req},   32'h0);
         next_cyc();
         mid();
         chk($sformatf("bad%0d_e2_hreadyout", k), {31'h0, HREADYOUT}, 32'h1);
         chk($sformatf("bad%0d_e2_hresp", k),     {31'h0, HRESP},     32'h1);
         chk($sformatf("bad%0d_e2_req", k),       {31'h0, reg_req},   32'h0);
         exp_err++;
      end
      next_cyc();
      mid();
      chk("bad_back_idle_hresp", {31'h0, HRESP}, 32'h0);

      // ---------------- backend timeout ----------------
      next_cyc();
      addr_ph(32'hF0F0_0004, 1'b0, 3'b010, c_nonseq);
      mid();
      for (int i = 0; i < 8; i++) begin
         next_cyc();
         bus_idle();
         mid();
         chk($sformatf("to_wait%0d_req", i),       {31'h0, reg_req},   32'h1);
         chk($sformatf("to_wait%0d_hreadyout", i), {31'h0, HREADYOUT}, 32'h0);
      end
      next_cyc();
      mid();
      chk("to_e1_req",       {31'h0, reg_req},   32'h0);
      chk("to_e1_hreadyout", {31'h0, HREADYOUT}, 32'h0);
      chk("to_e1_hresp",     {31'h0, HRESP},     32'h1);
      next_cyc();
      mid();
      chk("to_e2_hreadyout", {31'h0, HREADYOUT}, 32'h1);
      chk("to_e2_hresp",     {31'h0, HRESP},     32'h1);
      exp_err++;
      next_cyc();
      mid();
      chk_stats("to");

      // ---------------- INCR4 write burst, no bubbles ----------------
      for (int b = 0; b < 5; b++) begin
         next_cyc();
         if (b < 4) begin
            addr_ph(32'hF0F0_0000 + 32'(4 * b), 1'b1, 3'b010, (b == 0) ? c_nonseq : c_seq);
            HBURST = 3'b011;
         end else begin
            bus_idle();
         end
         if (b > 0) begin
            HWDATA  = 32'hA000_0000 + 32'(b - 1);
            reg_ack = 1'b1;
         end
         mid();
         if (b > 0) begin
            chk($sformatf("wb%0d_req", b - 1),   {31'h0, reg_req},   32'h1);
            chk($sformatf("wb%0d_idx", b - 1),   {28'h0, reg_idx},   32'(b - 1));
            chk($sformatf("wb%0d_wdata", b - 1), reg_wdata,          32'hA000_0000 + 32'(b - 1));
            chk($sformatf("wb%0d_ready", b - 1), {31'h0, HREADYOUT}, 32'h1);
            chk($sformatf("wb%0d_hresp", b - 1), {31'h0, HRESP},     32'h0);
            exp_ok++;
         end
      end
      next_cyc();
      reg_ack = 1'b0;
      HWDATA  = 32'h0;
      mid();
      chk("wb_done_req", {31'h0, reg_req}, 32'h0);

      // ---------------- INCR4 read burst with a BUSY beat ----------------
      rb_trans[0] = c_nonseq; rb_aidx[0] = 0; rb_didx[0] = -1;
      rb_trans[1] = c_seq;    rb_aidx[1] = 1; rb_didx[1] = 0;
      rb_trans[2] = c_busy;   rb_aidx[2] = 2; rb_didx[2] = 1;
      rb_trans[3] = c_seq;    rb_aidx[3] = 2; rb_didx[3] = -1;
      rb_trans[4] = c_seq;    rb_aidx[4] = 3; rb_didx[4] = 2;
      rb_trans[5] = c_idle;   rb_aidx[5] = 0; rb_didx[5] = 3;
      for (int c = 0; c < 6; c++) begin
         next_cyc();
         if (rb_trans[c] == c_idle) bus_idle();
         else begin
            addr_ph(32'hF0F0_0000 + 32'(4 * rb_aidx[c]), 1'b0, 3'b010, rb_trans[c]);
            HBURST = 3'b011;
         end
         reg_ack   = (rb_didx[c] >= 0);
         reg_rdata = (rb_didx[c] >= 0) ? (32'h5500_0000 | 32'(rb_didx[c])) : 32'h0;
         mid();
         chk($sformatf("rb_c%0d_ready", c), {31'h0, HREADYOUT}, 32'h1);
         chk($sformatf("rb_c%0d_hresp", c), {31'h0, HRESP},     32'h0);
         chk($sformatf("rb_c%0d_req", c),   {31'h0, reg_req},   (rb_didx[c] >= 0) ? 32'h1 : 32'h0);
         chk($sformatf("rb_c%0d_hrdata", c), HRDATA,
             (rb_didx[c] >= 0) ? (32'h5500_0000 | 32'(rb_didx[c])) : 32'h0);
         if (rb_didx[c] >= 0) begin
            chk($sformatf("rb_c%0d_idx", c), {28'h0, reg_idx}, 32'(rb_didx[c]));
            exp_ok++;
         end
      end
      next_cyc();
      reg_ack   = 1'b0;
      reg_rdata = 32'h0;
      mid();
      chk_stats("burst");

      // ---------------- reset during a waited read ----------------
      next_cyc();
      addr_ph(32'hF0F0_000C, 1'b0, 3'b010, c_nonseq);
      mid();
      next_cyc();
      bus_idle();
      mid();
      chk("mr_wait_req", {31'h0, reg_req}, 32'h1);
      next_cyc();
      rst = 1'b1;
      #1;
      chk("mr_req",       {31'h0, reg_req},   32'h0);
      chk("mr_hreadyout", {31'h0, HREADYOUT}, 32'h1);
      chk("mr_hresp",     {31'h0, HRESP},     32'h0);
      chk("mr_reg_idx",   {28'h0, reg_idx},   32'h0);
      exp_ok  = 0;
      exp_err = 0;
      chk_stats("mr");
      mid();
      next_cyc();
      rst = 1'b0;
      next_cyc();
      addr_ph(32'hF0F0_001C, 1'b1, 3'b010, c_nonseq);
      mid();
      next_cyc();
      bus_idle();
      HWDATA  = 32'h0BAD_F00D;
      reg_ack = 1'b1;
      mid();
      chk("pr_req",       {31'h0, reg_req},   32'h1);
      chk("pr_idx",       {28'h0, reg_idx},   32'h7);
      chk("pr_wdata",     reg_wdata,          32'h0BAD_F00D);
      chk("pr_hreadyout", {31'h0, HREADYOUT}, 32'h1);
      exp_ok++;
      next_cyc();
      reg_ack = 1'b0;
      HWDATA  = 32'h0;
      mid();
      chk_stats("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire
